// File: rtl/seven_segment_display_n_if.sv
// Bus bundle for the seven-segment display driver: load request, display
// options and the glyph / status results returned by the driver.
interface seven_segment_display_n_if #(
   parameter int DIGITS = 6,
   parameter int DATA_W = 20
);
   logic                  load;
   logic [DATA_W-1:0]     value;
   logic                  mode_hex;
   logic                  blank_lz;
   logic [DIGITS-1:0]     dp_in;
   logic                  busy;
   logic                  done;
   logic                  ovf;
   logic [8*DIGITS-1:0]   seg_out;

   modport master (
      output load, value, mode_hex, blank_lz, dp_in,
      input  busy, done, ovf, seg_out
   );

   modport slave (
      input  load, value, mode_hex, blank_lz, dp_in,
      output busy, done, ovf, seg_out
   );
endinterface

// File: rtl/seven_segment_display_n.sv
// N-digit seven-segment display driver. A binary value is converted to BCD
// serially (double-dabble, one bit per clock) or passed through as hex nibbles,
// then rendered to active-low glyphs with leading-zero blanking, decimal points
// and a dash pattern on overflow.
module seven_segment_display_n #(
   parameter int DIGITS = 6,
   parameter int DATA_W = 20
) (
   input  logic                      clk,
   input  logic                      rst_n,
   seven_segment_display_n_if.slave  bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_UPDATE  = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_bin;
   logic [BCD_W-1:0]    r_bcd;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ovf_int;
   logic                r_hex;
   logic                r_blz;
   logic [DIGITS-1:0]   r_dp;
   logic [8*DIGITS-1:0] r_seg;
   logic                r_ovf;
   logic                r_done;

   logic [BCD_W-1:0]    w_bcd_adj;
   logic [EXT_W-1:0]    w_ext;
   logic                w_hex_ovf;
   logic [BCD_W-1:0]    w_digits;
   logic                w_ovf_final;
   logic [8*DIGITS-1:0] w_glyphs;

   // Segment pattern a..g (bit0..bit6), active low, for one hex digit.
   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      case (d)
         4'h0:    f_glyph = 7'h40;
         4'h1:    f_glyph = 7'h79;
         4'h2:    f_glyph = 7'h24;
         4'h3:    f_glyph = 7'h30;
         4'h4:    f_glyph = 7'h19;
         4'h5:    f_glyph = 7'h12;
         4'h6:    f_glyph = 7'h02;
         4'h7:    f_glyph = 7'h78;
         4'h8:    f_glyph = 7'h00;
         4'h9:    f_glyph = 7'h10;
         4'hA:    f_glyph = 7'h08;
         4'hB:    f_glyph = 7'h03;
         4'hC:    f_glyph = 7'h46;
         4'hD:    f_glyph = 7'h21;
         4'hE:    f_glyph = 7'h06;
         4'hF:    f_glyph = 7'h0E;
         default: f_glyph = 7'h7F;
      endcase
   endfunction

   // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
   function automatic logic [BCD_W-1:0] f_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] res;
      res = b;
      for (int k = 0; k < DIGITS; k++) begin
         if (b[4*k +: 4] >= 4'd5) begin
            res[4*k +: 4] = b[4*k +: 4] + 4'd3;
         end else begin
            res[4*k +: 4] = b[4*k +: 4];
         end
      end
      return res;
   endfunction

   assign w_bcd_adj   = f_adjust(r_bcd);
   assign w_ext       = EXT_W'(r_bin);
   assign w_hex_ovf   = |(w_ext >> BCD_W);
   assign w_digits    = r_hex ? w_ext[BCD_W-1:0] : r_bcd;
   assign w_ovf_final = r_hex ? w_hex_ovf : r_ovf_int;

   // Render every digit: dashes on overflow, blanks above the leading digit, else glyphs.
   always_comb begin
      logic       v_seen;
      logic [3:0] v_d;
      v_seen   = 1'b0;
      v_d      = 4'h0;
      w_glyphs = '1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_d    = w_digits[4*i +: 4];
         v_seen = v_seen | (v_d != 4'h0);
         if (w_ovf_final) begin
            w_glyphs[8*i +: 8] = 8'hBF;
         end else if (r_blz && !v_seen && (i != 0)) begin
            w_glyphs[8*i +: 8] = {~r_dp[i], 7'h7F};
         end else begin
            w_glyphs[8*i +: 8] = {~r_dp[i], f_glyph(v_d)};
         end
      end
   end

   // Control FSM: accept, serial conversion, then one-cycle registered output update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_ovf_int <= 1'b0;
         r_hex     <= 1'b0;
         r_blz     <= 1'b0;
         r_dp      <= '0;
         r_seg     <= '1;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.load) begin
                  r_bin <= bus.value;
                  r_hex <= bus.mode_hex;
                  r_blz <= bus.blank_lz;
                  r_dp  <= bus.dp_in;
                  if (bus.mode_hex) begin
                     r_state <= S_UPDATE;
                  end else begin
                     r_bcd     <= '0;
                     r_ovf_int <= 1'b0;
                     r_cnt     <= CNT_W'(DATA_W);
                     r_state   <= S_CONVERT;
                  end
               end
            end
            S_CONVERT: begin
               r_done <= 1'b0;
               r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
               r_bin  <= {r_bin[DATA_W-2:0], 1'b0};
               if (w_bcd_adj[BCD_W-1]) begin
                  r_ovf_int <= 1'b1;
               end
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               r_seg   <= w_glyphs;
               r_ovf   <= w_ovf_final;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = r_done;
   assign bus.ovf     = r_ovf;
   assign bus.seg_out = r_seg;

endmodule

// File: tb/tb_seven_segment_display_n.sv
// Directed bench for seven_segment_display_n (DIGITS=6, DATA_W=20). Expected
// glyph words are queued when a load is issued and popped when done pulses.
module tb_seven_segment_display_n;

   localparam int DIGITS = 6;
   localparam int DATA_W = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seven_segment_display_n_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

   seven_segment_display_n #(.DIGITS(DIGITS), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [47:0] seg;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   n_err = 0;
   int   n_chk = 0;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one load strobe; optionally queue its expected result.
   task automatic start(input logic [19:0] v, input logic hex, input logic blz,
                        input logic [5:0] dp, input logic [47:0] eseg,
                        input logic eovf, input bit push);
      exp_t e;
      @(negedge clk);
      bus.value    = v;
      bus.mode_hex = hex;
      bus.blank_lz = blz;
      bus.dp_in    = dp;
      bus.load     = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      if (push) begin
         e.seg = eseg;
         e.ovf = eovf;
         sb.push_back(e);
      end
   endtask

   // Wait (bounded) for done, check latency, busy profile and the queued result.
   // glitch > 0 pulses load with a different value while the conversion runs.
   task automatic wait_done(input string tag, input int exp_lat, input int glitch);
      int   n;
      bit   got;
      bit   busy_bad;
      exp_t e;
      n        = 0;
      got      = 1'b0;
      busy_bad = (bus.busy !== 1'b1);
      while (!got && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (n == glitch) begin
            bus.load  = 1'b1;
            bus.value = 20'd7;
         end else if (n == glitch + 1) begin
            bus.load = 1'b0;
         end
         if (bus.done === 1'b1) begin
            got = 1'b1;
         end else if (bus.busy !== 1'b1) begin
            busy_bad = 1'b1;
         end
      end
      bus.load = 1'b0;
      chk({tag, " latency"}, 48'(got ? n : 999), 48'(exp_lat));
      chk({tag, " busy during"}, 48'(busy_bad), 48'd0);
      if (got) begin
         chk({tag, " busy at done"}, 48'(bus.busy), 48'd0);
         if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 48'd1, 48'd0);
         end else begin
            e = sb.pop_front();
            chk({tag, " seg"}, bus.seg_out, e.seg);
            chk({tag, " ovf"}, 48'(bus.ovf), 48'(e.ovf));
         end
      end
   endtask

   initial begin
      int n_done;
      bus.load     = 1'b0;
      bus.value    = '0;
      bus.mode_hex = 1'b0;
      bus.blank_lz = 1'b0;
      bus.dp_in    = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset seg", bus.seg_out, 48'hFFFFFFFFFFFF);
      chk("reset busy", 48'(bus.busy), 48'd0);
      chk("reset done", 48'(bus.done), 48'd0);
      chk("reset ovf", 48'(bus.ovf), 48'd0);
      rst_n = 1'b1;

      // Decimal conversion, no blanking
      start(20'd123456, 1'b0, 1'b0, 6'b000000, 48'hF9A4B0999282, 1'b0, 1'b1);
      wait_done("dec123456", 21, -1);

      // Load in the done cycle, leading-zero blanking and a decimal point
      start(20'd42, 1'b0, 1'b1, 6'b000010, 48'hFFFFFFFF19A4, 1'b0, 1'b1);
      wait_done("dec42", 21, -1);

      // Hex pass-through
      start(20'hABCDE, 1'b1, 1'b0, 6'b000000, 48'hC08883C6A186, 1'b0, 1'b1);
      wait_done("hexABCDE", 1, -1);

      // Output holds between updates
      repeat (5) @(posedge clk);
      #1;
      chk("hold seg", bus.seg_out, 48'hC08883C6A186);
      chk("hold done", 48'(bus.done), 48'd0);

      // Hex with interior zero, blanking and dp on a blanked digit
      start(20'h00305, 1'b1, 1'b1, 6'b100000, 48'h7FFFFFB0C092, 1'b0, 1'b1);
      wait_done("hex305", 1, -1);

      // Decimal overflow: dashes, dp ignored
      start(20'd1000000, 1'b0, 1'b0, 6'b111111, 48'hBFBFBFBFBFBF, 1'b1, 1'b1);
      wait_done("dec1000000", 21, -1);

      // Zero with blanking clears overflow and shows a single 0
      start(20'd0, 1'b0, 1'b1, 6'b000000, 48'hFFFFFFFFFFC0, 1'b0, 1'b1);
      wait_done("dec0", 21, -1);

      // Load pulses and input changes during CONVERT are ignored
      start(20'd123456, 1'b0, 1'b0, 6'b000000, 48'hF9A4B0999282, 1'b0, 1'b1);
      wait_done("ignore load", 21, 5);

      // Reset mid-conversion abandons it
      start(20'd999999, 1'b0, 1'b0, 6'b000000, 48'h0, 1'b0, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst seg", bus.seg_out, 48'hFFFFFFFFFFFF);
      chk("midrst busy", 48'(bus.busy), 48'd0);
      chk("midrst ovf", 48'(bus.ovf), 48'd0);
      rst_n  = 1'b1;
      n_done = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) n_done++;
      end
      chk("midrst no done", 48'(n_done), 48'd0);

      // Conversion after the abandoned one
      start(20'd987654, 1'b0, 1'b0, 6'b000000, 48'h9080F8829299, 1'b0, 1'b1);
      wait_done("dec987654", 21, -1);

      chk("scoreboard drained", 48'(sb.size()), 48'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
